// File: rtl/rf_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_CNT_W  = 16;

   typedef enum logic {RF_INIT = 1'b0, RF_RUN = 1'b1} rf_state_e;
   typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} rf_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req/grant_c bit 0 = ALU, bit 1 = MEM.
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant_c
);

   rf_src_e ptr;
   rf_src_e ptr_next;

   always_ff @(posedge clk) begin
      if (rst) ptr <= SRC_MEM;
      else     ptr <= ptr_next;
   end

   // Pointer only moves after a genuine contention cycle.
   always_comb begin
      grant_c  = 2'b00;
      ptr_next = ptr;
      if (en) begin
         if (&req) begin
            grant_c  = (ptr == SRC_MEM) ? 2'b10 : 2'b01;
            ptr_next = (ptr == SRC_MEM) ? SRC_ALU : SRC_MEM;
         end else begin
            grant_c = req;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: post-reset clear sweep, then ALU/load arbitration.
// Define RF_WB_STATS_EN to add the saturating conflict_cnt port.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned CNT_W  = RF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
`ifdef RF_WB_STATS_EN
   output logic [CNT_W-1:0]  conflict_cnt,
`endif
   output logic              init_done
);

   localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

   if (ADDR_W < 1 || DATA_W < 1 || CNT_W < 1) begin : g_param_check
      $error("rf_wb_arbiter: widths must be non-zero");
   end

   rf_state_e         state;
   rf_state_e         state_next;
   logic [ADDR_W-1:0] sweep_addr;
   logic [ADDR_W-1:0] sweep_next;
   logic              we_next;
   logic [ADDR_W-1:0] waddr_next;
   logic [DATA_W-1:0] wdata_next;
   logic              run_c;
   logic [1:0]        grant_c;

   assign run_c     = (state == RF_RUN);
   assign alu_ready = grant_c[0];
   assign mem_ready = grant_c[1];

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .en      (run_c),
      .req     ({mem_valid, alu_valid}),
      .grant_c (grant_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RF_INIT;
         sweep_addr <= ADDR_W'(1);
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         init_done  <= 1'b0;
      end else begin
         state      <= state_next;
         sweep_addr <= sweep_next;
         rf_we      <= we_next;
         rf_waddr   <= waddr_next;
         rf_wdata   <= wdata_next;
         init_done  <= run_c;
      end
   end

   // Writes to r0 are swallowed; address/data hold whenever nothing is written.
   always_comb begin
      state_next = state;
      sweep_next = sweep_addr;
      we_next    = 1'b0;
      waddr_next = rf_waddr;
      wdata_next = rf_wdata;
      case (state)
         RF_INIT: begin
            we_next    = 1'b1;
            waddr_next = sweep_addr;
            wdata_next = '0;
            sweep_next = sweep_addr + ADDR_W'(1);
            if (sweep_addr == SWEEP_LAST) state_next = RF_RUN;
         end
         RF_RUN: begin
            if (grant_c[1] && (mem_rd != '0)) begin
               we_next    = 1'b1;
               waddr_next = mem_rd;
               wdata_next = mem_data;
            end else if (grant_c[0] && (alu_rd != '0)) begin
               we_next    = 1'b1;
               waddr_next = alu_rd;
               wdata_next = alu_data;
            end
         end
         default: state_next = RF_INIT;
      endcase
   end

`ifdef RF_WB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)                                               conflict_cnt <= '0;
      else if (run_c && alu_valid && mem_valid && (~conflict_cnt != '0)) conflict_cnt <= conflict_cnt + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised bench for rf_wb_arbiter against a transaction-level queue model.
module tb_rf_wb_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 16;
   localparam int unsigned NREG = 1 << AW;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } req_t;

   logic          clk;
   logic          rst;
   logic          alu_valid, mem_valid;
   logic [AW-1:0] alu_rd, mem_rd;
   logic [DW-1:0] alu_data, mem_data;
   logic          alu_ready, mem_ready;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          init_done;

   int tests = 0;
   int fails = 0;

   req_t aq[$];
   req_t mq[$];
   bit   prefer_mem;
   longint conflicts;

`ifdef RF_WB_STATS_EN
   logic [CW-1:0] conflict_cnt;
   logic          sat_valid;
   logic          sat_alu_ready, sat_mem_ready, sat_we, sat_done;
   logic [AW-1:0] sat_waddr;
   logic [DW-1:0] sat_wdata;
   logic [1:0]    sat_cnt;
`endif

   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .mem_ready    (mem_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
`ifdef RF_WB_STATS_EN
      .conflict_cnt (conflict_cnt),
`endif
      .init_done    (init_done)
   );

`ifdef RF_WB_STATS_EN
   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (sat_valid),
      .alu_rd       (AW'(3)),
      .alu_data     (DW'(32'h11)),
      .alu_ready    (sat_alu_ready),
      .mem_valid    (sat_valid),
      .mem_rd       (AW'(4)),
      .mem_data     (DW'(32'h22)),
      .mem_ready    (sat_mem_ready),
      .rf_we        (sat_we),
      .rf_waddr     (sat_waddr),
      .rf_wdata     (sat_wdata),
      .conflict_cnt (sat_cnt),
      .init_done    (sat_done)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_from_queues();
      alu_valid = (aq.size() > 0);
      mem_valid = (mq.size() > 0);
      alu_rd    = alu_valid ? aq[0].rd   : '0;
      alu_data  = alu_valid ? aq[0].data : '0;
      mem_rd    = mem_valid ? mq[0].rd   : '0;
      mem_data  = mem_valid ? mq[0].data : '0;
   endtask

   // Entered and left at posedge+1.
   task automatic apply_reset(input int cycles);
      aq.delete();
      mq.delete();
      drive_from_queues();
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      chk("rst_we", 64'(rf_we), 64'(0));
      chk("rst_waddr", 64'(rf_waddr), 64'(0));
      chk("rst_wdata", 64'(rf_wdata), 64'(0));
      chk("rst_done", 64'(init_done), 64'(0));
`ifdef RF_WB_STATS_EN
      chk("rst_cnt", 64'(conflict_cnt), 64'(0));
`endif
      rst        = 1'b0;
      prefer_mem = 1'b1;
      conflicts  = 0;
   endtask

   // Clear sweep; an ALU request is offered during most of it and must never be accepted.
   // Returns early (abort=1) if stop_at is reached so a mid-sweep reset can be tested.
   task automatic sweep(input int stop_at, output bit abort);
      abort = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         alu_valid = (i < NREG - 2);
         alu_rd    = AW'(7);
         alu_data  = DW'(32'hBAD0_0000 + i);
         @(posedge clk);
         #1;
         chk("sweep_we", 64'(rf_we), 64'(1));
         chk("sweep_waddr", 64'(rf_waddr), 64'(i));
         chk("sweep_wdata", 64'(rf_wdata), 64'(0));
         chk("sweep_done", 64'(init_done), 64'(0));
         if (i < NREG - 2) chk("sweep_ready", 64'({alu_ready, mem_ready}), 64'(0));
         if (i == stop_at) begin
            alu_valid = 1'b0;
            abort = 1'b1;
            return;
         end
      end
      alu_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_sweep_we", 64'(rf_we), 64'(0));
      chk("post_sweep_done", 64'(init_done), 64'(1));
   endtask

   // One RUN cycle: model decides the grant from queue occupancy and preference.
   task automatic run_cycle(output int granted);
      bit   av, mv, g_alu, g_mem, exp_we;
      req_t w;
      drive_from_queues();
      av = alu_valid;
      mv = mem_valid;
      g_mem = mv && (!av || prefer_mem);
      g_alu = av && !g_mem;
      #2;
      chk("alu_ready", 64'(alu_ready), 64'(g_alu));
      chk("mem_ready", 64'(mem_ready), 64'(g_mem));
      if (av && mv) begin
         prefer_mem = !prefer_mem;
         conflicts++;
      end
      granted = g_mem ? 2 : (g_alu ? 1 : 0);
      exp_we = 1'b0;
      w = '{rd: '0, data: '0};
      if (g_mem) w = mq.pop_front();
      if (g_alu) w = aq.pop_front();
      if ((g_mem || g_alu) && w.rd != 0) exp_we = 1'b1;
      @(posedge clk);
      #1;
      chk("wb_we", 64'(rf_we), 64'(exp_we));
      if (exp_we) begin
         chk("wb_waddr", 64'(rf_waddr), 64'(w.rd));
         chk("wb_wdata", 64'(rf_wdata), 64'(w.data));
      end
      chk("run_done", 64'(init_done), 64'(1));
`ifdef RF_WB_STATS_EN
      chk("conflict_cnt", 64'(conflict_cnt), 64'(conflicts > 64'hFFFF ? 64'hFFFF : conflicts));
`endif
   endtask

   initial begin
      bit   ab;
      int   g;
      int   order[$];
      rst = 1'b1;
`ifdef RF_WB_STATS_EN
      sat_valid = 1'b0;
`endif
      @(posedge clk);
      apply_reset(2);
      sweep(NREG, ab);

      // Contention x4 with immediate replacement: MEM, ALU, MEM, ALU.
      for (int k = 0; k < 4; k++) begin
         aq.push_back('{rd: AW'(10 + k), data: DW'(32'hA000 + k)});
         mq.push_back('{rd: AW'(20 + k), data: DW'(32'hB000 + k)});
      end
      for (int k = 0; k < 4; k++) begin
         run_cycle(g);
         order.push_back(g);
      end
      chk("rr_order", 64'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}),
          64'({2'd2, 2'd1, 2'd2, 2'd1}));
      while (aq.size() > 0 || mq.size() > 0) run_cycle(g);

      aq.push_back('{rd: AW'(5), data: DW'(32'hDEADBEEF)});
      run_cycle(g);
      chk("alu_only_grant", 64'(g), 64'(1));

      mq.push_back('{rd: AW'(0), data: DW'(32'h1234)});
      run_cycle(g);
      chk("r0_grant", 64'(g), 64'(2));

      run_cycle(g);
      chk("idle_hold_waddr", 64'(rf_waddr), 64'(5));

      // Random traffic; requests hold until accepted because they stay at queue heads.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0)
            aq.push_back('{rd: ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1)),
                           data: DW'($urandom)});
         if ($urandom_range(0, 2) == 0)
            mq.push_back('{rd: ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1)),
                           data: DW'($urandom)});
         run_cycle(g);
      end

      // Reset while requests are pending mid-RUN, then one pulse mid-sweep at address 10.
      aq.push_back('{rd: AW'(9), data: DW'(32'h99)});
      drive_from_queues();
      apply_reset(1);
      sweep(10, ab);
      chk("sweep_abort_at_10", 64'(ab), 64'(1));
      apply_reset(1);
      sweep(NREG, ab);

      for (int c = 0; c < 100; c++) begin
         if ($urandom_range(0, 1) == 0) aq.push_back('{rd: AW'($urandom_range(0, NREG - 1)), data: DW'($urandom)});
         if ($urandom_range(0, 1) == 0) mq.push_back('{rd: AW'($urandom_range(0, NREG - 1)), data: DW'($urandom)});
         run_cycle(g);
      end

`ifdef RF_WB_STATS_EN
      chk("sat_done", 64'(sat_done), 64'(1));
      sat_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("sat_cnt_3", 64'(sat_cnt), 64'(3));
      repeat (3) @(posedge clk);
      #1;
      chk("sat_cnt_hold", 64'(sat_cnt), 64'(3));
      sat_valid = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
